// File: rtl/obstacle_manager_if.sv
// Game-side bundle for obstacle_manager: tick/start/over/LFSR inputs and packed per-slot outputs.
interface obstacle_manager_if #(
    parameter int NUM_OBS = 2,
    parameter int POS_W   = 8
);
    logic                       i_tick;
    logic                       i_start;
    logic                       i_over;
    logic [7:0]                 i_rng;
    logic [NUM_OBS*POS_W-1:0]   o_pos;
    logic [NUM_OBS*3-1:0]       o_type;
    logic [NUM_OBS-1:0]         o_active;
    logic [1:0]                 o_speed;
    logic                       o_spawn;

    modport master (
        output i_tick, i_start, i_over, i_rng,
        input  o_pos, o_type, o_active, o_speed, o_spawn
    );

    modport slave (
        input  i_tick, i_start, i_over, i_rng,
        output o_pos, o_type, o_active, o_speed, o_spawn
    );
endinterface

// File: rtl/obstacle_manager.sv
// NUM_OBS-slot scrolling obstacle engine with randomised spawn spacing.
// Optional feature macro OBS_SPEEDUP_EN: step the scroll speed up every SPEEDUP_TICKS running ticks.
module obstacle_manager #(
    parameter int NUM_OBS       = 2,
    parameter int POS_W         = 8,
    parameter int GEN_LINE      = 120,
    parameter int MIN_GAP       = 40,
    parameter int SPEEDUP_TICKS = 600,
    parameter int MAX_SPEED     = 3
) (
    input logic               clk,
    input logic               rst,
    obstacle_manager_if.slave bus
);
    localparam int IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;

    if (NUM_OBS < 1 || NUM_OBS > 8 || MAX_SPEED < 1 || MAX_SPEED > 3 ||
        SPEEDUP_TICKS < 1 || MIN_GAP + 31 > 255 || GEN_LINE >= (1 << POS_W)) begin : g_bad_cfg
        $error("obstacle_manager: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    state_t                 state_q, state_d;
    logic [POS_W-1:0]       pos_q  [NUM_OBS];
    logic [POS_W-1:0]       pos_d  [NUM_OBS];
    logic [2:0]             type_q [NUM_OBS];
    logic [2:0]             type_d [NUM_OBS];
    logic [NUM_OBS-1:0]     active_q, active_d;
    logic [1:0]             speed_q, speed_d;
    logic [7:0]             gap_cnt_q, gap_cnt_d;
    logic [7:0]             gap_target_q, gap_target_d;
    logic [7:0]             gap_sum;
    logic                   spawn_q, spawn_d;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic                   run_tick;

`ifdef OBS_SPEEDUP_EN
    localparam int SPD_CNT_W = (SPEEDUP_TICKS > 1) ? $clog2(SPEEDUP_TICKS) : 1;
    localparam logic [1:0] SPEED_CAP = 2'(MAX_SPEED);
    logic [SPD_CNT_W-1:0]   speed_cnt_q, speed_cnt_d;

    function automatic logic [1:0] speed_step_sat(input logic [1:0] s);
        return (s < SPEED_CAP) ? s + 2'd1 : s;
    endfunction
`endif

    function automatic logic [7:0] gap_add_sat(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Priority start > over > tick; an over in RUN swallows a coincident tick.
    assign run_tick = (state_q == RUN) && !bus.i_start && !bus.i_over && bus.i_tick;

    always_comb begin
        state_d = state_q;
        if (bus.i_start) begin
            state_d = RUN;
        end else if (state_q == RUN && bus.i_over) begin
            state_d = FROZEN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pos_d        = pos_q;
        type_d       = type_q;
        active_d     = active_q;
        speed_d      = speed_q;
        gap_cnt_d    = gap_cnt_q;
        gap_target_d = gap_target_q;
        spawn_d      = 1'b0;
        gap_sum      = gap_cnt_q;
        free_found   = 1'b0;
        free_idx     = '0;
`ifdef OBS_SPEEDUP_EN
        speed_cnt_d  = speed_cnt_q;
`endif
        if (bus.i_start) begin
            for (int k = 0; k < NUM_OBS; k++) begin
                pos_d[k]  = '0;
                type_d[k] = '0;
            end
            active_d     = '0;
            speed_d      = 2'd1;
            gap_cnt_d    = '0;
            gap_target_d = 8'(MIN_GAP);
`ifdef OBS_SPEEDUP_EN
            speed_cnt_d  = '0;
`endif
        end else if (run_tick) begin
            // Free slots are judged before this tick's retirements.
            for (int k = NUM_OBS - 1; k >= 0; k--) begin
                if (!active_q[k]) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(k);
                end
            end
            for (int k = 0; k < NUM_OBS; k++) begin
                if (active_q[k]) begin
                    if (pos_q[k] > POS_W'(speed_q)) begin
                        pos_d[k] = pos_q[k] - POS_W'(speed_q);
                    end else begin
                        pos_d[k]    = '0;
                        active_d[k] = 1'b0;
                    end
                end
            end
            gap_sum   = gap_add_sat(gap_cnt_q, speed_q);
            gap_cnt_d = gap_sum;
            if (gap_sum >= gap_target_q && free_found) begin
                pos_d[free_idx]    = POS_W'(GEN_LINE);
                type_d[free_idx]   = bus.i_rng[2:0];
                active_d[free_idx] = 1'b1;
                gap_cnt_d          = '0;
                gap_target_d       = 8'(MIN_GAP) + {3'b000, bus.i_rng[7:3]};
                spawn_d            = 1'b1;
            end
`ifdef OBS_SPEEDUP_EN
            if (speed_cnt_q == SPD_CNT_W'(SPEEDUP_TICKS - 1)) begin
                speed_cnt_d = '0;
                speed_d     = speed_step_sat(speed_q);
            end else begin
                speed_cnt_d = speed_cnt_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_OBS; k++) begin
                pos_q[k]  <= '0;
                type_q[k] <= '0;
            end
            active_q     <= '0;
            speed_q      <= 2'd1;
            gap_cnt_q    <= '0;
            gap_target_q <= 8'(MIN_GAP);
            spawn_q      <= 1'b0;
`ifdef OBS_SPEEDUP_EN
            speed_cnt_q  <= '0;
`endif
        end else begin
            pos_q        <= pos_d;
            type_q       <= type_d;
            active_q     <= active_d;
            speed_q      <= speed_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_target_q <= gap_target_d;
            spawn_q      <= spawn_d;
`ifdef OBS_SPEEDUP_EN
            speed_cnt_q  <= speed_cnt_d;
`endif
        end
    end

    for (genvar k = 0; k < NUM_OBS; k++) begin : g_pack
        assign bus.o_pos[k*POS_W +: POS_W] = pos_q[k];
        assign bus.o_type[k*3 +: 3]        = type_q[k];
    end

    assign bus.o_active = active_q;
    assign bus.o_speed  = speed_q;
    assign bus.o_spawn  = spawn_q;

endmodule

// File: tb/tb_obstacle_manager.sv
// Bench for obstacle_manager: directed scenarios plus randomised play against a behavioural model.
module tb_obstacle_manager;
    localparam int NUM_OBS       = 2;
    localparam int POS_W         = 8;
    localparam int GEN_LINE      = 120;
    localparam int MIN_GAP       = 40;
    localparam int SPEEDUP_TICKS = 4;
    localparam int MAX_SPEED     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    obstacle_manager_if #(.NUM_OBS(NUM_OBS), .POS_W(POS_W)) bus ();

    obstacle_manager #(
        .NUM_OBS(NUM_OBS), .POS_W(POS_W), .GEN_LINE(GEN_LINE), .MIN_GAP(MIN_GAP),
        .SPEEDUP_TICKS(SPEEDUP_TICKS), .MAX_SPEED(MAX_SPEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural model: 0 idle, 1 running, 2 frozen
    int m_state;
    int m_pos  [NUM_OBS];
    int m_type [NUM_OBS];
    bit m_act  [NUM_OBS];
    int m_speed, m_gap, m_target, m_ticks_since_step;
    bit m_spawn;

    function automatic void model_clear();
        for (int k = 0; k < NUM_OBS; k++) begin
            m_pos[k] = 0; m_type[k] = 0; m_act[k] = 1'b0;
        end
        m_speed = 1; m_gap = 0; m_target = MIN_GAP; m_ticks_since_step = 0;
    endfunction

    task automatic model_step(input bit t, input bit s, input bit o, input int r);
        int first_free;
        m_spawn = 1'b0;
        if (rst) begin
            m_state = 0;
            model_clear();
        end else if (s) begin
            m_state = 1;
            model_clear();
        end else if (m_state == 1 && o) begin
            m_state = 2;
        end else if (m_state == 1 && t) begin
            first_free = -1;
            for (int k = 0; k < NUM_OBS; k++)
                if (!m_act[k] && first_free < 0) first_free = k;
            for (int k = 0; k < NUM_OBS; k++) begin
                if (m_act[k]) begin
                    if (m_pos[k] > m_speed) m_pos[k] = m_pos[k] - m_speed;
                    else begin m_pos[k] = 0; m_act[k] = 1'b0; end
                end
            end
            m_gap = (m_gap + m_speed > 255) ? 255 : m_gap + m_speed;
            if (m_gap >= m_target && first_free >= 0) begin
                m_pos[first_free]  = GEN_LINE;
                m_type[first_free] = r % 8;
                m_act[first_free]  = 1'b1;
                m_gap    = 0;
                m_target = MIN_GAP + r / 8;
                m_spawn  = 1'b1;
            end
`ifdef OBS_SPEEDUP_EN
            m_ticks_since_step++;
            if (m_ticks_since_step == SPEEDUP_TICKS) begin
                m_ticks_since_step = 0;
                if (m_speed < MAX_SPEED) m_speed++;
            end
`endif
        end
    endtask

    function automatic logic [NUM_OBS*POS_W-1:0] exp_pos();
        logic [NUM_OBS*POS_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_OBS; k++) v[k*POS_W +: POS_W] = POS_W'(m_pos[k]);
        return v;
    endfunction

    function automatic logic [NUM_OBS*3-1:0] exp_type();
        logic [NUM_OBS*3-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_OBS; k++) v[k*3 +: 3] = 3'(m_type[k]);
        return v;
    endfunction

    function automatic logic [NUM_OBS-1:0] exp_active();
        logic [NUM_OBS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_OBS; k++) v[k] = m_act[k];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pos",    64'(bus.o_pos),    64'(exp_pos()));
            check("model_type",   64'(bus.o_type),   64'(exp_type()));
            check("model_active", 64'(bus.o_active), 64'(exp_active()));
            check("model_speed",  64'(bus.o_speed),  64'(m_speed));
            check("model_spawn",  64'(bus.o_spawn),  64'(m_spawn));
        end
    end

    task automatic cycle(input bit t, input bit s, input bit o, input logic [7:0] r);
        bus.i_tick = t; bus.i_start = s; bus.i_over = o; bus.i_rng = r;
        @(posedge clk);
        model_step(t, s, o, int'(r));
        #1;
    endtask

    task automatic tick(input logic [7:0] r);
        cycle(1'b0, 1'b0, 1'b0, 8'h3C);
        cycle(1'b1, 1'b0, 1'b0, r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_tick = 1'b0; bus.i_start = 1'b0; bus.i_over = 1'b0; bus.i_rng = 8'h00;
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check("rst_pos",    64'(bus.o_pos),    64'h0);
        check("rst_type",   64'(bus.o_type),   64'h0);
        check("rst_active", 64'(bus.o_active), 64'h0);
        check("rst_speed",  64'(bus.o_speed),  64'd1);
        check("rst_spawn",  64'(bus.o_spawn),  64'h0);

        // Ticks in IDLE must be ignored
        for (int i = 0; i < 5; i++) tick(8'h05);
        check("idle_active", 64'(bus.o_active), 64'h0);

`ifndef OBS_SPEEDUP_EN
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 39; i++) tick(8'h05);
        check("t39_no_spawn", 64'(bus.o_spawn),  64'h0);
        check("t39_active",   64'(bus.o_active), 64'h0);
        tick(8'h05);
        check("t40_spawn",  64'(bus.o_spawn),      64'h1);
        check("t40_pos0",   64'(bus.o_pos[7:0]),   64'd120);
        check("t40_type0",  64'(bus.o_type[2:0]),  64'd5);
        check("t40_active", 64'(bus.o_active),     64'b01);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("spawn_pulse_width", 64'(bus.o_spawn), 64'h0);
        for (int i = 41; i <= 60; i++) tick(8'h05);
        check("t60_pos0", 64'(bus.o_pos[7:0]), 64'd100);
        for (int i = 61; i <= 80; i++) tick(8'h05);
        check("t80_spawn",  64'(bus.o_spawn),     64'h1);
        check("t80_active", 64'(bus.o_active),    64'b11);
        check("t80_pos1",   64'(bus.o_pos[15:8]), 64'd120);
        for (int i = 81; i <= 120; i++) tick(8'h05);
        check("t120_deferred", 64'(bus.o_spawn),  64'h0);
        check("t120_active",   64'(bus.o_active), 64'b11);
        for (int i = 121; i <= 159; i++) tick(8'h05);
        check("t159_pos0", 64'(bus.o_pos[7:0]), 64'd1);
        tick(8'h05);
        check("t160_retire_active", 64'(bus.o_active),   64'b10);
        check("t160_retire_pos0",   64'(bus.o_pos[7:0]), 64'd0);
        check("t160_no_spawn",      64'(bus.o_spawn),    64'h0);
        tick(8'h05);
        check("t161_spawn",  64'(bus.o_spawn),  64'h1);
        check("t161_pos",    64'(bus.o_pos),    64'h2778);
        check("t161_active", 64'(bus.o_active), 64'b11);
        check("speed_const", 64'(bus.o_speed),  64'd1);

        cycle(1'b1, 1'b0, 1'b1, 8'h05);
        for (int i = 0; i < 100; i++) tick(8'h05);
        check("frozen_pos",    64'(bus.o_pos),    64'h2778);
        check("frozen_active", 64'(bus.o_active), 64'b11);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("restart_active", 64'(bus.o_active), 64'h0);
        check("restart_pos",    64'(bus.o_pos),    64'h0);
        check("restart_speed",  64'(bus.o_speed),  64'd1);

        cycle(1'b1, 1'b1, 1'b0, 8'h05);
        check("start_tick_pos", 64'(bus.o_pos), 64'h0);
        for (int i = 1; i <= 39; i++) tick(8'h05);
        check("start_tick_t39", 64'(bus.o_spawn), 64'h0);
        tick(8'h05);
        check("start_tick_t40", 64'(bus.o_spawn), 64'h1);
`else
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            tick(8'($urandom));
            if (i == 3)  check("speed_t3",  64'(bus.o_speed), 64'd1);
            if (i == 4)  check("speed_t4",  64'(bus.o_speed), 64'd2);
            if (i == 7)  check("speed_t7",  64'(bus.o_speed), 64'd2);
            if (i == 8)  check("speed_t8",  64'(bus.o_speed), 64'd3);
            if (i == 20) check("speed_t20", 64'(bus.o_speed), 64'd3);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h05);
        check("start_tick_pos",   64'(bus.o_pos),   64'h0);
        check("start_tick_speed", 64'(bus.o_speed), 64'd1);
`endif

        // Randomised play, with occasional start/over/reset
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 1499) == 0);
            cycle(1'($urandom_range(0, 1) == 0),
                  1'($urandom_range(0, 1199) == 0),
                  1'($urandom_range(0, 899) == 0),
                  8'($urandom));
        end
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
